// File: rtl/experiment_sequencer.sv
// experiment_sequencer: a shot sequencer with multi-channel staggered detonation.
// The sequence is: start -> gate opto -> open delay -> staggered detonator pulses
// -> wire sensor -> output trigger -> detector handshake.
// Each waiting stage can time out. Abort, fault codes and a shot counter are included.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   start, abort              scenario start level (already synchronised), abort request level
//   fg_opto, wire_sensor      gate opto sensor and wire break sensor (edge detected internally)
//   detector_ready            detector ready level
//   det_mask                  channel enable mask, sampled when leaving IDLE
//   fg_open_delay .. ready_timeout
//                             live timing inputs, CNT_W wide; a timeout of 0 waits forever
//   det_fire, output_trigger  registered pulse outputs
//   busy, done, fault         status flags
//   fault_code                0 none, 1 opto timeout, 2 wire timeout,
//                             3 detector-busy timeout, 4 abort
//   scenario_state            state encoding, zero-extended to 8 bits
//   shot_count                number of completed shots, wraps at 2^SHOT_W
module experiment_sequencer #(
    parameter int unsigned N_DET  = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SHOT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              fg_opto,
    input  logic              wire_sensor,
    input  logic              detector_ready,
    input  logic [N_DET-1:0]  det_mask,
    input  logic [CNT_W-1:0]  fg_open_delay,
    input  logic [CNT_W-1:0]  det_len,
    input  logic [CNT_W-1:0]  det_gap,
    input  logic [CNT_W-1:0]  trigger_len,
    input  logic [CNT_W-1:0]  opto_timeout,
    input  logic [CNT_W-1:0]  wire_timeout,
    input  logic [CNT_W-1:0]  ready_timeout,
    output logic [N_DET-1:0]  det_fire,
    output logic              output_trigger,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [7:0]        scenario_state,
    output logic [SHOT_W-1:0] shot_count
);

    localparam int unsigned CH_W = (N_DET > 1) ? $clog2(N_DET) : 1;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_OPTO  = 3'd1;
    localparam logic [2:0] FC_WIRE  = 3'd2;
    localparam logic [2:0] FC_READY = 3'd3;
    localparam logic [2:0] FC_ABORT = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_OPTO  = 4'd1,
        S_OPEN_DELAY = 4'd2,
        S_FIRE       = 4'd3,
        S_GAP        = 4'd4,
        S_WAIT_WIRE  = 4'd5,
        S_TRIGGER    = 4'd6,
        S_DET_BUSY   = 4'd7,
        S_DET_WAIT   = 4'd8,
        S_DONE       = 4'd9,
        S_FAULT      = 4'd10
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [N_DET-1:0]    mask_q, mask_d;
    logic [1:0]          start_h_q, start_h_d;
    logic [1:0]          opto_h_q, opto_h_d;
    logic [1:0]          wire_h_q, wire_h_d;
    logic [N_DET-1:0]    det_fire_q, det_fire_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [2:0]          code_q, code_d;
    logic [SHOT_W-1:0]   shot_q, shot_d;

    logic                start_rise, opto_rise, wire_rise;
    logic [CNT_W-1:0]    cnt_inc;
    logic [N_DET-1:0]    ch_onehot;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                next_found;
    logic                fault_go;
    logic [2:0]          fault_sel;

    // A rise is seen as history 01: the older sample is low and the newer sample is high.
    assign start_rise = ~start_h_q[1] & start_h_q[0];
    assign opto_rise  = ~opto_h_q[1]  & opto_h_q[0];
    assign wire_rise  = ~wire_h_q[1]  & wire_h_q[0];

    // The counter saturates so that stages that wait forever never wrap into a false timeout.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign ch_onehot = N_DET'(1) << ch_q;

    // Lowest enabled channel in the incoming mask, and the next enabled channel above ch_q.
    // Both loops scan from the top bit down, so the lowest matching bit is assigned last and wins.
    always_comb begin
        first_ch   = '0;
        next_ch    = ch_q;
        next_found = 1'b0;
        for (int unsigned i = 0; i < N_DET; i++) begin
            if (det_mask[N_DET-1-i]) begin
                first_ch = CH_W'(N_DET-1-i);
            end
            if (mask_q[N_DET-1-i] && ((N_DET-1-i) > 32'(ch_q))) begin
                next_ch    = CH_W'(N_DET-1-i);
                next_found = 1'b1;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        mask_d     = mask_q;
        det_fire_d = det_fire_q;
        trig_d     = trig_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fault_d    = fault_q;
        code_d     = code_q;
        shot_d     = shot_q;
        start_h_d  = {start_h_q[0], start};
        opto_h_d   = {opto_h_q[0], fg_opto};
        wire_h_d   = {wire_h_q[0], wire_sensor};
        fault_go   = 1'b0;
        fault_sel  = FC_NONE;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    mask_d  = det_mask;
                    ch_d    = first_ch;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                    state_d = S_WAIT_OPTO;
                end
            end
            S_WAIT_OPTO: begin
                // The awaited edge is checked before the timeout, so the edge wins a tie.
                if (opto_rise) begin
                    cnt_d   = '0;
                    state_d = S_OPEN_DELAY;
                end else begin
                    cnt_d = cnt_inc;
                    if ((opto_timeout != '0) && (cnt_inc >= opto_timeout)) begin
                        fault_go  = 1'b1;
                        fault_sel = FC_OPTO;
                    end
                end
            end
            S_OPEN_DELAY: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= fg_open_delay) begin
                    cnt_d = '0;
                    if (mask_q == '0) begin
                        state_d = S_WAIT_WIRE;
                    end else begin
                        state_d    = S_FIRE;
                        det_fire_d = (det_len != '0) ? ch_onehot : '0;
                    end
                end
            end
            S_FIRE: begin
                // The pulse is raised on the entry edge, so it is high for exactly det_len cycles.
                cnt_d = cnt_inc;
                if (cnt_inc >= det_len) begin
                    cnt_d      = '0;
                    det_fire_d = '0;
                    if (next_found) begin
                        ch_d    = next_ch;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_WAIT_WIRE;
                    end
                end else begin
                    det_fire_d = ch_onehot;
                end
            end
            S_GAP: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= det_gap) begin
                    cnt_d      = '0;
                    state_d    = S_FIRE;
                    det_fire_d = (det_len != '0) ? ch_onehot : '0;
                end
            end
            S_WAIT_WIRE: begin
                if (wire_rise) begin
                    cnt_d   = '0;
                    trig_d  = (trigger_len != '0);
                    state_d = S_TRIGGER;
                end else begin
                    cnt_d = cnt_inc;
                    if ((wire_timeout != '0) && (cnt_inc >= wire_timeout)) begin
                        fault_go  = 1'b1;
                        fault_sel = FC_WIRE;
                    end
                end
            end
            S_TRIGGER: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= trigger_len) begin
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                    state_d = S_DET_BUSY;
                end
            end
            S_DET_BUSY: begin
                if (!detector_ready) begin
                    cnt_d   = '0;
                    state_d = S_DET_WAIT;
                end
            end
            S_DET_WAIT: begin
                if (detector_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    shot_d  = shot_q + SHOT_W'(1);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if ((ready_timeout != '0) && (cnt_inc >= ready_timeout)) begin
                        fault_go  = 1'b1;
                        fault_sel = FC_READY;
                    end
                end
            end
            S_DONE, S_FAULT: begin
                // A return to IDLE is required before the next start rise counts.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                det_fire_d = '0;
                trig_d     = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // Abort overrides any stage transition or timeout taken above.
        if (abort && (state_q inside {S_WAIT_OPTO, S_OPEN_DELAY, S_FIRE, S_GAP,
                                      S_WAIT_WIRE, S_TRIGGER, S_DET_BUSY, S_DET_WAIT})) begin
            fault_go  = 1'b1;
            fault_sel = FC_ABORT;
        end

        if (fault_go) begin
            state_d    = S_FAULT;
            cnt_d      = '0;
            det_fire_d = '0;
            trig_d     = 1'b0;
            busy_d     = 1'b0;
            fault_d    = 1'b1;
            code_d     = fault_sel;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            mask_q     <= '0;
            start_h_q  <= '0;
            opto_h_q   <= '0;
            wire_h_q   <= '0;
            det_fire_q <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
            shot_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            start_h_q  <= start_h_d;
            opto_h_q   <= opto_h_d;
            wire_h_q   <= wire_h_d;
            det_fire_q <= det_fire_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            shot_q     <= shot_d;
        end
    end

    assign det_fire       = det_fire_q;
    assign output_trigger = trig_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fault          = fault_q;
    assign fault_code     = code_q;
    assign scenario_state = 8'(state_q);
    assign shot_count     = shot_q;

endmodule

// File: doc/experiment_sequencer.md
Name: experiment_sequencer

Overview:
- Parametrised next-generation experiment sequencer: start -> gate opto -> gate-open delay -> multi-channel staggered detonation -> wire sensor -> output trigger -> detector handshake.
- Adds per-stage timeouts, abort, fault reporting, a channel-enable mask, inter-channel stagger and a shot counter.
- Sits between the input-conditioning block and the status/register interface, in the same slot as the single-channel experiment FSM.

Parameters:
- N_DET, 4, number of detonator channels (1..8).
- CNT_W, 32, width of all delay/length/timeout fields and the internal counter.
- SHOT_W, 16, shot counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  scenario start level (already synchronised)
- abort  in  1  abort request level
- fg_opto  in  1  gate opto sensor
- wire_sensor  in  1  wire break sensor
- detector_ready  in  1  detector ready level
- det_mask  in  N_DET  channel enable mask, sampled at IDLE exit
- fg_open_delay  in  CNT_W  cycles from opto edge to first fire
- det_len  in  CNT_W  fire pulse width per channel
- det_gap  in  CNT_W  idle cycles between consecutive channel pulses
- trigger_len  in  CNT_W  output trigger pulse width
- opto_timeout, wire_timeout, ready_timeout  in  CNT_W  stage timeouts; 0 = wait forever
- det_fire  out  N_DET  registered detonator pulses
- output_trigger  out  1  registered trigger pulse
- busy, done, fault  out  1  status flags
- fault_code  out  3  0 none, 1 opto timeout, 2 wire timeout, 3 detector-busy timeout, 4 abort
- scenario_state  out  8  zero-extended state encoding
- shot_count  out  SHOT_W  completed shots

Behaviour:
- Reset is synchronous, at clock edge, and overrides everything. On reset:
  - state=IDLE; all outputs 0; counter and edge history cleared.
  - shot_count=0.
  - Reset mid-pulse drops det_fire/output_trigger on the next edge.
- Edge detect: each of start, fg_opto and wire_sensor has a 2-bit history. A rise is history==01, so the state change occurs 2 edges after the input is first sampled high.
- State encodings:
  - 0 IDLE, 1 WAIT_OPTO, 2 OPEN_DELAY, 3 FIRE, 4 GAP, 5 WAIT_WIRE, 6 TRIGGER, 7 DET_BUSY, 8 DET_WAIT, 9 DONE, 10 FAULT.
- IDLE: on start rise, latch det_mask into mask_q, set channel index ch=lowest set bit, counter=0, busy=1, clear done/fault/fault_code -> WAIT_OPTO.
- WAIT_OPTO: on fg_opto rise -> OPEN_DELAY with counter=0. Otherwise the counter increments; if opto_timeout!=0 and the counter reaches opto_timeout -> FAULT, code 1.
- OPEN_DELAY: counts fg_open_delay cycles, then -> FIRE with counter=0.
  - If mask_q==0, skip directly to WAIT_WIRE instead.
- FIRE: det_fire[ch]=1 for exactly det_len cycles.
  - det_len=0 produces no pulse and takes 1 cycle.
  - Then advance ch to the next set bit of mask_q: if one exists -> GAP, else -> WAIT_WIRE.
  - Only one det_fire bit is ever high at a time.
- GAP: all det_fire=0 for det_gap cycles -> FIRE.
- WAIT_WIRE: on wire_sensor rise -> TRIGGER. Timeout as in WAIT_OPTO, using wire_timeout, code 2.
  - A wire rise during FIRE/GAP is ignored; only rises seen in WAIT_WIRE count.
- TRIGGER: output_trigger=1 for exactly trigger_len cycles -> DET_BUSY.
- DET_BUSY: when detector_ready==0 -> DET_WAIT with counter=0. No timeout in this state.
- DET_WAIT: when detector_ready==1 -> DONE.
  - If ready_timeout!=0 and the counter reaches ready_timeout -> FAULT, code 3.
- DONE:
  - On entry: done=1, busy=0, shot_count+1, wrapping at 2^SHOT_W.
  - Stays while start==1; start==0 -> IDLE, done retained until the next start rise.
- FAULT:
  - On entry: fault=1, busy=0, det_fire=0, output_trigger=0.
  - Stays while start==1; start==0 -> IDLE.
  - shot_count is not incremented.
- abort==1 in any state other than IDLE/DONE/FAULT -> FAULT, code 4, next edge; outputs are forced 0 on that same edge.
  - Abort has priority over a simultaneous stage transition or timeout.
- Simultaneous events:
  - Timeout and the awaited edge in the same cycle: the edge wins.
  - A start rise in DONE/FAULT is ignored; a return to IDLE is required first.
- Parameter inputs are read live, except det_mask. They must be held stable during a shot; behaviour under change is undefined beyond the counter comparing against the current value.
- Counter compare is unsigned, CNT_W wide, and saturates (no wrap) in states that wait forever.
- Illegal state -> IDLE.

Test Plan:
- Nominal, N_DET=4, mask=4'b0101, fg_open_delay=10, det_len=5, det_gap=3, trigger_len=4: start rise, opto rise, wire rise, ready low then high.
  -> det_fire[0] high 5 cycles, 0 for 3 cycles, det_fire[2] high 5 cycles; output_trigger high 4 cycles; done=1; shot_count=1; fault=0.
- opto_timeout=20, no opto edge -> FAULT exactly 20 cycles after WAIT_OPTO entry; fault_code=1; det_fire never asserted.
- abort pulsed mid-FIRE on channel 0 -> det_fire=0 on the next edge; fault_code=4; start low -> scenario_state=0.
- mask=0 -> no det_fire activity; WAIT_WIRE entered 1 cycle after the delay expires.
- ready_timeout=8, detector_ready held 0 -> FAULT code 3; shot_count unchanged.
- Reset asserted mid-TRIGGER -> output_trigger=0, scenario_state=0, shot_count=0 on the next edge.
- Shot counter wrap, SHOT_W=2: 5 full shots -> shot_count=1.
